// File: rtl/baggage_drop_ctrl.sv
// Baggage drop controller: captures four height sensors, averages them,
// derives a fall time with a bit-serial square root, and decides whether to
// drop, hold, or report a cold (too fast) condition.
module baggage_drop_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  sensor1,
    input  logic [7:0]  sensor2,
    input  logic [7:0]  sensor3,
    input  logic [7:0]  sensor4,
    input  logic [15:0] t_lim,
    input  logic        drop_en,
    output logic        busy,
    output logic        done,
    output logic [7:0]  height,
    output logic [15:0] t_act,
    output logic [1:0]  msg_sel,
    output logic        drop_activated
);

    localparam int unsigned SENS_W  = 8;
    localparam int unsigned SUM_W   = 10;
    localparam int unsigned ROOT_W  = 12;
    localparam int unsigned RAD_W   = 24;
    localparam int unsigned REM_W   = 14;
    localparam int unsigned TRY_W   = 16;
    localparam int unsigned TIME_W  = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SQRT_LAST = ROOT_W - 1;

    localparam logic [1:0] MSG_COLD = 2'b01;
    localparam logic [1:0] MSG_DROP = 2'b10;
    localparam logic [1:0] MSG_HOLD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_AVG,
        S_SQRT,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t              state;
    logic [SENS_W-1:0]   s1_q;
    logic [SENS_W-1:0]   s2_q;
    logic [SENS_W-1:0]   s3_q;
    logic [SENS_W-1:0]   s4_q;
    logic [TIME_W-1:0]   lim_q;
    logic                en_q;
    logic [RAD_W-1:0]    rad_q;
    logic [REM_W-1:0]    rem_q;
    logic [ROOT_W-1:0]   root_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [SUM_W-1:0]    sum_c;
    logic [SENS_W-1:0]   avg_c;
    logic [TRY_W-1:0]    rem_try_c;
    logic [TRY_W-1:0]    trial_c;
    logic [TIME_W-1:0]   t_new_c;

    // Rounded mean, one restoring sqrt step, and fall time from the final root
    always_comb begin
        sum_c     = SUM_W'(s1_q) + SUM_W'(s2_q) + SUM_W'(s3_q) + SUM_W'(s4_q)
                  + SUM_W'(2);
        avg_c     = sum_c[SUM_W-1:2];
        rem_try_c = {rem_q, rad_q[RAD_W-1:RAD_W-2]};
        trial_c   = {2'b00, root_q, 2'b01};
        t_new_c   = {4'b0000, root_q} >> 1;
    end

    // Control FSM with registered status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            height         <= '0;
            t_act          <= '0;
            msg_sel        <= '0;
            drop_activated <= 1'b0;
            s1_q           <= '0;
            s2_q           <= '0;
            s3_q           <= '0;
            s4_q           <= '0;
            lim_q          <= '0;
            en_q           <= 1'b0;
            rad_q          <= '0;
            rem_q          <= '0;
            root_q         <= '0;
            cnt_q          <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                // cancel keeps all previously published results
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state <= S_CAPTURE;
                            busy  <= 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        s1_q  <= sensor1;
                        s2_q  <= sensor2;
                        s3_q  <= sensor3;
                        s4_q  <= sensor4;
                        lim_q <= t_lim;
                        en_q  <= drop_en;
                        state <= S_AVG;
                    end
                    S_AVG: begin
                        height <= avg_c;
                        rad_q  <= {avg_c, 16'h0000};
                        rem_q  <= '0;
                        root_q <= '0;
                        cnt_q  <= '0;
                        state  <= S_SQRT;
                    end
                    S_SQRT: begin
                        if (rem_try_c >= trial_c) begin
                            rem_q  <= REM_W'(rem_try_c - trial_c);
                            root_q <= {root_q[ROOT_W-2:0], 1'b1};
                        end else begin
                            rem_q  <= REM_W'(rem_try_c);
                            root_q <= {root_q[ROOT_W-2:0], 1'b0};
                        end
                        rad_q <= {rad_q[RAD_W-3:0], 2'b00};
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(SQRT_LAST)) begin
                            state <= S_DECIDE;
                        end
                    end
                    S_DECIDE: begin
                        t_act <= t_new_c;
                        if (t_new_c < lim_q) begin
                            msg_sel        <= MSG_COLD;
                            drop_activated <= 1'b0;
                        end else if (en_q) begin
                            msg_sel        <= MSG_DROP;
                            drop_activated <= 1'b1;
                        end else begin
                            msg_sel        <= MSG_HOLD;
                            drop_activated <= 1'b0;
                        end
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// Directed self-checking bench for baggage_drop_ctrl.
module tb_baggage_drop_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  sensor1;
    logic [7:0]  sensor2;
    logic [7:0]  sensor3;
    logic [7:0]  sensor4;
    logic [15:0] t_lim;
    logic        drop_en;
    logic        busy;
    logic        done;
    logic [7:0]  height;
    logic [15:0] t_act;
    logic [1:0]  msg_sel;
    logic        drop_activated;

    int checks   = 0;
    int failures = 0;

    // Start edge to first cycle with done visible; DONE is the 16th cycle
    // counting the CAPTURE cycle as the first.
    localparam int DONE_LAT = 15;

    baggage_drop_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .sensor1        (sensor1),
        .sensor2        (sensor2),
        .sensor3        (sensor3),
        .sensor4        (sensor4),
        .t_lim          (t_lim),
        .drop_en        (drop_en),
        .busy           (busy),
        .done           (done),
        .height         (height),
        .t_act          (t_act),
        .msg_sel        (msg_sel),
        .drop_activated (drop_activated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input logic [15:0] lim, input logic en);
        sensor1 = a;
        sensor2 = b;
        sensor3 = c;
        sensor4 = d;
        t_lim   = lim;
        drop_en = en;
    endtask

    // Pulse start at a negedge, wait (bounded) for done, then check results
    task automatic run(input string tag, input logic [7:0] eh, input logic [15:0] et,
                       input logic [1:0] em, input logic ed);
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"},    32'(n),              32'(DONE_LAT));
        check({tag, "_height"}, 32'(height),         32'(eh));
        check({tag, "_t_act"},  32'(t_act),          32'(et));
        check({tag, "_msg"},    32'(msg_sel),        32'(em));
        check({tag, "_drop"},   32'(drop_activated), 32'(ed));
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 32'(0));
        check({tag, "_idle"},      32'(busy), 32'(0));
    endtask

    initial begin
        int dones;
        int first;
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_inputs(8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 1'b0);

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",   32'(busy),           32'(0));
        check("rst_done",   32'(done),           32'(0));
        check("rst_height", 32'(height),         32'(0));
        check("rst_t_act",  32'(t_act),          32'(0));
        check("rst_msg",    32'(msg_sel),        32'(0));
        check("rst_drop",   32'(drop_activated), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 80s: root 2289, t_act 1144 >= 1000, drop enabled
        set_inputs(8'd80, 8'd80, 8'd80, 8'd80, 16'd1000, 1'b1);
        run("s80", 8'd80, 16'd1144, 2'b10, 1'b1);

        // (10+20+30+41+2)>>2 = 25, root 1280, t_act 640 == t_lim -> HOLD
        set_inputs(8'd10, 8'd20, 8'd30, 8'd41, 16'd640, 1'b0);
        run("mix", 8'd25, 16'd640, 2'b11, 1'b0);

        // Zero height, back-to-back with previous run
        set_inputs(8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 1'b1);
        run("zero_lim0", 8'd0, 16'd0, 2'b10, 1'b1);
        set_inputs(8'd0, 8'd0, 8'd0, 8'd0, 16'd1, 1'b1);
        run("zero_lim1", 8'd0, 16'd0, 2'b01, 1'b0);

        // 255s: root 4087, t_act 2043; inputs scrambled during SQRT
        set_inputs(8'd255, 8'd255, 8'd255, 8'd255, 16'hFFFF, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        set_inputs(8'd3, 8'd0, 8'd200, 8'd1, 16'd0, 1'b0);
        first = 4;
        while (!done && first < 40) begin
            @(negedge clk);
            first++;
        end
        check("s255_lat",    32'(first),          32'(DONE_LAT));
        check("s255_height", 32'(height),         32'(255));
        check("s255_t_act",  32'(t_act),          32'(2043));
        check("s255_msg",    32'(msg_sel),        32'(1));
        check("s255_drop",   32'(drop_activated), 32'(0));
        @(negedge clk);

        // start re-pulsed while busy is ignored: exactly one done
        set_inputs(8'd80, 8'd80, 8'd80, 8'd80, 16'd1000, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first == 0) first = i;
            end
            start = (i == 4 || i == 9);
        end
        start = 1'b0;
        check("busy_start_dones", 32'(dones), 32'(1));
        check("busy_start_lat",   32'(first), 32'(DONE_LAT));
        check("busy_start_t_act", 32'(t_act), 32'(1144));

        // Abort during SQRT: idle next edge, no done, old decision kept
        set_inputs(8'd255, 8'd255, 8'd255, 8'd255, 16'hFFFF, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", 32'(busy), 32'(0));
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones),          32'(0));
        check("abort_height",  32'(height),         32'(255));
        check("abort_t_act",   32'(t_act),          32'(1144));
        check("abort_msg",     32'(msg_sel),        32'(2));
        check("abort_drop",    32'(drop_activated), 32'(1));

        // start and abort together in IDLE: abort wins, nothing queued
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'(0));
        @(negedge clk);
        check("start_abort_noq", 32'(busy), 32'(0));

        // Reset mid-SQRT clears outputs without a clock edge
        set_inputs(8'd10, 8'd20, 8'd30, 8'd41, 16'd640, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_sqrt_pre_busy",   32'(busy),   32'(1));
        check("rst_sqrt_pre_height", 32'(height), 32'(25));
        rst_n = 1'b0;
        #1;
        check("rst_sqrt_busy",   32'(busy),           32'(0));
        check("rst_sqrt_height", 32'(height),         32'(0));
        check("rst_sqrt_t_act",  32'(t_act),          32'(0));
        check("rst_sqrt_msg",    32'(msg_sel),        32'(0));
        check("rst_sqrt_drop",   32'(drop_activated), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_inputs(8'd80, 8'd80, 8'd80, 8'd80, 16'd1000, 1'b1);
        run("post_rst", 8'd80, 16'd1144, 2'b10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
